// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: bundles the EX/MEM/WB/ID hazard-unit signals; FWD_HAZARD_STATS_EN adds the stat counters
interface fwd_hazard_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2
);
  logic                    flush;
  logic                    ex_stall;
  logic [5*NUM_SRC-1:0]    ex_rs;
  logic [XLEN*NUM_SRC-1:0] ex_rs_data;
  logic [5*NUM_SRC-1:0]    id_rs;
  logic                    id_valid;
  logic [4:0]              ex_rd;
  logic                    ex_regwrite;
  logic                    ex_is_load;
  logic [4:0]              mem_rd;
  logic                    mem_regwrite;
  logic [XLEN-1:0]         mem_result;
  logic [4:0]              wb_rd;
  logic                    wb_regwrite;
  logic [XLEN-1:0]         wb_result;
  logic                    lc_issue;
  logic [4:0]              lc_rd;
  logic                    lc_wb;
  logic [XLEN*NUM_SRC-1:0] fwd_data;
  logic [2*NUM_SRC-1:0]    fwd_sel;
  logic                    stall_id;
  logic                    sb_busy;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]             stat_stall_cycles;
  logic [31:0]             stat_fwd_count;
  modport slave (
    input  flush, ex_stall, ex_rs, ex_rs_data, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result, lc_issue, lc_rd, lc_wb,
    output fwd_data, fwd_sel, stall_id, sb_busy, stat_stall_cycles, stat_fwd_count
  );
  modport master (
    output flush, ex_stall, ex_rs, ex_rs_data, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result, lc_issue, lc_rd, lc_wb,
    input  fwd_data, fwd_sel, stall_id, sb_busy, stat_stall_cycles, stat_fwd_count
  );
`else
  modport slave (
    input  flush, ex_stall, ex_rs, ex_rs_data, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result, lc_issue, lc_rd, lc_wb,
    output fwd_data, fwd_sel, stall_id, sb_busy
  );
  modport master (
    output flush, ex_stall, ex_rs, ex_rs_data, id_rs, id_valid, ex_rd, ex_regwrite, ex_is_load,
           mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result, lc_issue, lc_rd, lc_wb,
    input  fwd_data, fwd_sel, stall_id, sb_busy
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: MEM/WB operand forwarding, hold registers, load-use and mul/div scoreboard stalls; FWD_HAZARD_STATS_EN adds stall/forward counters
module fwd_hazard_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NREG    = 32
) (
  input logic            clk,
  input logic            rst_n,
  fwd_hazard_if.slave    bus
);
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};
  logic [NREG-1:0]         r_pending;
  logic [NUM_SRC-1:0]      r_hold_vld;
  logic [XLEN-1:0]         r_hold [NUM_SRC];
  logic [31:0]             w_pend;
  logic [31:0]             w_set;
  logic [31:0]             w_clr;
  logic [NUM_SRC-1:0]      w_mem_hit;
  logic [NUM_SRC-1:0]      w_wb_hit;
  logic [NUM_SRC-1:0]      w_cap;
  logic [2*NUM_SRC-1:0]    w_sel;
  logic [XLEN*NUM_SRC-1:0] w_data;
  logic                    w_lu;
  logic                    w_raw;
  logic                    w_waw;
  logic                    w_stall;

  assign w_pend = 32'(r_pending & X0_MASK);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [4:0] w_rs;
    assign w_rs         = bus.ex_rs[5*i +: 5];
    assign w_mem_hit[i] = bus.mem_regwrite && bus.mem_rd != 5'd0 && bus.mem_rd == w_rs;
    assign w_wb_hit[i]  = bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == w_rs;
    assign w_cap[i]     = bus.ex_stall && w_wb_hit[i] && !w_mem_hit[i];
    assign w_sel[2*i +: 2] = w_mem_hit[i] ? 2'd1 :
                             w_wb_hit[i] ? 2'd2 :
                             (r_hold_vld[i] && w_rs != 5'd0) ? 2'd3 : 2'd0;
    assign w_data[XLEN*i +: XLEN] = w_mem_hit[i] ? bus.mem_result :
                                    w_wb_hit[i] ? bus.wb_result :
                                    (r_hold_vld[i] && w_rs != 5'd0) ? r_hold[i] :
                                    bus.ex_rs_data[XLEN*i +: XLEN];
  end

  assign bus.fwd_sel  = w_sel;
  assign bus.fwd_data = w_data;

  // ID-side hazards: load-use against EX, RAW against outstanding mul/div results
  always_comb begin
    w_lu  = 1'b0;
    w_raw = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_lu  = w_lu | (bus.id_valid && bus.ex_regwrite && bus.ex_is_load && bus.ex_rd != 5'd0 &&
                      bus.ex_rd == bus.id_rs[5*k +: 5]);
      w_raw = w_raw | (bus.id_valid && w_pend[bus.id_rs[5*k +: 5]]);
    end
  end

  assign w_waw        = bus.lc_issue && w_pend[bus.lc_rd];
  assign w_stall      = w_lu || w_raw || w_waw;
  assign w_set        = (bus.lc_issue && !w_stall) ? 32'd1 << bus.lc_rd : 32'd0;
  assign w_clr        = (bus.wb_regwrite && bus.lc_wb) ? 32'd1 << bus.wb_rd : 32'd0;
  assign bus.stall_id = w_stall;
  assign bus.sb_busy  = |r_pending;

  // scoreboard: set on mul/div issue, clear on its writeback, set wins on collision; x0 never tracked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pending <= '0;
    else r_pending <= ((r_pending & ~w_clr[NREG-1:0]) | w_set[NREG-1:0]) & X0_MASK;

  // hold registers: keep a WB value that retires while EX is frozen; dropped on unfreeze or flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hold_vld <= '0;
      for (int k = 0; k < NUM_SRC; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++)
        if (bus.flush || !bus.ex_stall) r_hold_vld[k] <= 1'b0;
        else if (w_cap[k]) begin
          r_hold_vld[k] <= 1'b1;
          r_hold[k]     <= bus.wb_result;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic [32:0] w_fwd_sum;

  // forwarded-operand total for this cycle, widened so saturation can be detected
  always_comb begin
    w_fwd_sum = {1'b0, r_fwd_cnt};
    for (int k = 0; k < NUM_SRC; k++)
      w_fwd_sum = w_fwd_sum + 33'(!bus.ex_stall && w_sel[2*k +: 2] != 2'd0);
  end

  // saturating statistics counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      r_fwd_cnt <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
    end

  assign bus.stat_stall_cycles = r_stall_cnt;
  assign bus.stat_fwd_count    = r_fwd_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard-driven check of forwarding priority, hold registers, load-use and mul/div stalls, async reset
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  string       tq[$];
  int          kq[$];
  logic [63:0] eq[$];

  always #5 clk = ~clk;

  fwd_hazard_if #(.XLEN(32), .NUM_SRC(2)) bus ();
  fwd_hazard_unit #(.XLEN(32), .NUM_SRC(2), .NREG(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int k);
    case (k)
      0: return 64'(bus.fwd_data[31:0]);
      1: return 64'(bus.fwd_data[63:32]);
      2: return 64'(bus.fwd_sel[1:0]);
      3: return 64'(bus.fwd_sel[3:2]);
      4: return 64'(bus.stall_id);
      default: return 64'(bus.sb_busy);
    endcase
  endfunction

  task automatic push(input string tag, input int k, input logic [63:0] v);
    tq.push_back(tag);
    kq.push_back(k);
    eq.push_back(v);
  endtask

  task automatic drain();
    string t;
    int k;
    logic [63:0] v;
    while (kq.size() > 0) begin
      t = tq.pop_front();
      k = kq.pop_front();
      v = eq.pop_front();
      check(t, obs(k), v);
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.ex_stall = 0; bus.ex_rs = '0; bus.ex_rs_data = {32'hBBBB, 32'hAAAA};
    bus.id_rs = '0; bus.id_valid = 0; bus.ex_rd = '0; bus.ex_regwrite = 0; bus.ex_is_load = 0;
    bus.mem_rd = '0; bus.mem_regwrite = 0; bus.mem_result = '0;
    bus.wb_rd = '0; bus.wb_regwrite = 0; bus.wb_result = '0;
    bus.lc_issue = 0; bus.lc_rd = '0; bus.lc_wb = 0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #2;
    push("rst_sel0", 2, 0); push("rst_sel1", 3, 0); push("rst_stall", 4, 0);
    push("rst_busy", 5, 0); push("rst_data0", 0, 32'hAAAA); push("rst_data1", 1, 32'hBBBB);
    drain();
    @(negedge clk) rst_n = 1;

    go(); bus.ex_rs = {5'd6, 5'd5};
    bus.mem_rd = 5; bus.mem_regwrite = 1; bus.mem_result = 32'h11;
    bus.wb_rd = 5; bus.wb_regwrite = 1; bus.wb_result = 32'h22;
    push("mem_pri_data", 0, 32'h11); push("mem_pri_sel", 2, 1); push("mem_pri_sel1", 3, 0);
    sample();
    go(); bus.mem_regwrite = 0;
    push("wb_data", 0, 32'h22); push("wb_sel", 2, 2);
    sample();
    go(); bus.ex_rs = {5'd6, 5'd0}; bus.wb_rd = 6;
    push("wb_op1_data", 1, 32'h22); push("wb_op1_sel", 3, 2); push("op0_x0_sel", 2, 0);
    sample();
    go(); idle(); bus.ex_rs = {5'd0, 5'd0}; bus.mem_rd = 0; bus.mem_regwrite = 1; bus.mem_result = 32'hDEAD;
    push("x0_data1", 1, 32'hBBBB); push("x0_sel1", 3, 0);
    sample();

    go(); idle(); bus.ex_regwrite = 1; bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs = {5'd0, 5'd7}; bus.id_valid = 1;
    push("lu_stall", 4, 1);
    sample();
    go(); bus.ex_regwrite = 0; bus.ex_is_load = 0; bus.ex_rd = 0;
    push("lu_bubble", 4, 0);
    sample();
    go(); bus.ex_regwrite = 1; bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs = {5'd7, 5'd0}; bus.id_valid = 0;
    push("lu_novalid", 4, 0);
    sample();
    go(); bus.id_valid = 1;
    push("lu_op1", 4, 1);
    sample();
    go(); bus.ex_is_load = 0;
    push("lu_notload", 4, 0);
    sample();

    go(); idle(); bus.lc_issue = 1; bus.lc_rd = 9;
    push("sb_issue_stall", 4, 0); push("sb_issue_busy", 5, 0);
    sample();
    go(); idle(); bus.id_rs = {5'd9, 5'd0}; bus.id_valid = 1;
    push("sb_raw_stall", 4, 1); push("sb_raw_busy", 5, 1);
    sample();
    go(); idle(); bus.lc_issue = 1; bus.lc_rd = 9;
    push("sb_waw_stall", 4, 1);
    sample();
    go(); idle(); bus.id_rs = {5'd9, 5'd0}; bus.id_valid = 1;
    bus.wb_regwrite = 1; bus.lc_wb = 1; bus.wb_rd = 9;
    push("sb_clr_edge_stall", 4, 1); push("sb_clr_edge_busy", 5, 1);
    sample();
    go(); idle(); bus.id_rs = {5'd9, 5'd0}; bus.id_valid = 1;
    push("sb_release_stall", 4, 0); push("sb_release_busy", 5, 0);
    sample();
    go(); idle(); bus.lc_issue = 1; bus.lc_rd = 10; bus.wb_regwrite = 1; bus.lc_wb = 1; bus.wb_rd = 10;
    sample();
    go(); idle();
    push("sb_set_wins", 5, 1);
    sample();
    go(); idle(); bus.wb_regwrite = 1; bus.lc_wb = 1; bus.wb_rd = 10;
    sample();
    go(); idle();
    push("sb_clr10", 5, 0);
    sample();

    go(); idle(); bus.ex_stall = 1; bus.ex_rs = {5'd0, 5'd3}; bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_result = 32'hABCD;
    push("hold_cap_sel", 2, 2); push("hold_cap_data", 0, 32'hABCD);
    sample();
    go(); bus.wb_regwrite = 0; bus.wb_result = 0;
    push("hold_sel", 2, 3); push("hold_data", 0, 32'hABCD);
    sample();
    go(); bus.wb_regwrite = 1; bus.wb_result = 32'h1234;
    sample();
    go(); bus.wb_regwrite = 0;
    push("hold_newer", 0, 32'h1234);
    sample();
    go(); bus.flush = 1;
    push("hold_flush_cycle", 2, 3);
    sample();
    go(); bus.flush = 0;
    push("hold_flushed_sel", 2, 0); push("hold_flushed_data", 0, 32'hAAAA);
    sample();
    go(); bus.wb_regwrite = 1; bus.wb_result = 32'h55;
    sample();
    go(); bus.wb_regwrite = 0; bus.ex_stall = 0;
    push("hold_unstall_cycle", 2, 3);
    sample();
    go();
    push("hold_unstalled", 2, 0);
    sample();
    go(); bus.ex_stall = 1; bus.wb_regwrite = 1; bus.wb_result = 32'h66; bus.mem_regwrite = 1; bus.mem_rd = 3; bus.mem_result = 32'h77;
    push("hold_mem_sel", 2, 1);
    sample();
    go(); bus.wb_regwrite = 0; bus.mem_regwrite = 0;
    push("hold_mem_nocap", 2, 0);
    sample();

    go(); idle(); bus.ex_stall = 1; bus.ex_rs = {5'd0, 5'd3}; bus.wb_regwrite = 1; bus.wb_rd = 3;
    bus.wb_result = 32'h99; bus.lc_issue = 1; bus.lc_rd = 4;
    sample();
    go(); idle(); bus.ex_stall = 1; bus.ex_rs = {5'd0, 5'd3};
    #1;
    push("pre_rst_busy", 5, 1); push("pre_rst_sel", 2, 3);
    drain();
    #1 rst_n = 0;
    #1;
    push("async_rst_busy", 5, 0); push("async_rst_sel", 2, 0); push("async_rst_data", 0, 32'hAAAA);
    drain();
    @(negedge clk) rst_n = 1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised operand-forwarding and hazard unit for the 5-stage RV32 pipeline, sitting between ID/EX and the ALU operand muxes. It supports N source operands with MEM/WB bypass, load-use stall detection, and a per-register scoreboard for long-latency (mul/div) writebacks. Per-operand hold registers keep a WB value that would otherwise be lost while EX is frozen.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, number of source operands checked (1..3)
NREG, 32, architectural register count; x0 is never forwarded, stalled or tracked

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (branch/trap)
ex_stall  in  1  EX stage frozen this cycle
ex_rs  in  5*NUM_SRC  EX source register numbers, operand i at [5i+4:5i]
ex_rs_data  in  XLEN*NUM_SRC  register-file values for EX operands
id_rs  in  5*NUM_SRC  ID source register numbers
id_valid  in  1  ID holds a valid instruction
ex_rd, ex_regwrite, ex_is_load  in  5,1,1  EX destination info
mem_rd, mem_regwrite  in  5,1  EX/MEM destination info
mem_result  in  XLEN  EX/MEM ALU result
wb_rd, wb_regwrite  in  5,1  MEM/WB destination info
wb_result  in  XLEN  MEM/WB write-back value
lc_issue, lc_rd  in  1,5  long-latency op leaves ID for the mul/div unit
lc_wb  in  1  current WB write comes from the mul/div unit
fwd_data  out  XLEN*NUM_SRC  forwarded operands
fwd_sel  out  2*NUM_SRC  per operand: 0 regfile, 1 MEM, 2 WB, 3 hold
stall_id  out  1  freeze PC/IF/ID and insert bubble into EX
sb_busy  out  1  any scoreboard bit set

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. All state is cleared on reset, and the outputs then follow the combinational rules below.
- Reset clears pending[NREG-1:1]=0 and hold_vld=0. With idle inputs, stall_id=0, sb_busy=0, fwd_sel=0 and fwd_data=ex_rs_data.
- Per-operand priority, combinational:
  - MEM, when mem_regwrite, mem_rd!=0 and mem_rd==rs.
  - Else WB, under the same test on wb_rd.
  - Else hold, when hold_vld[i].
  - Else the regfile value.
  - rs==0 always selects the regfile.
- Hold register i:
  - Captures wb_result on a clock edge when ex_stall=1, wb_regwrite=1, wb_rd!=0, wb_rd==ex_rs[i], and MEM does not match rs[i].
  - A newer WB capture overwrites it.
  - Cleared on the first edge with ex_stall=0, or on any edge with flush=1 (flush wins).
- Load-use stall: stall_id=1 if ex_regwrite, ex_is_load, ex_rd!=0 and ex_rd==any id_rs with id_valid. This holds for exactly one cycle per hazard, because the EX bubble removes the match.
- Scoreboard:
  - On an edge with lc_issue=1, stall_id=0 and lc_rd!=0, set pending[lc_rd].
  - On an edge with wb_regwrite, lc_wb and wb_rd!=0, clear pending[wb_rd].
  - Simultaneous set and clear of the same register: set wins.
  - stall_id=1 while any valid id_rs has its pending bit set (RAW).
  - stall_id=1 while lc_issue and pending[lc_rd] (WAW): stall until cleared.
  - Scoreboard RAW stall releases in the cycle after the clearing WB edge. The same-cycle WB bypass to ID is not required; the regfile write-first handles it.
- flush clears hold_vld but not pending. In-flight mul/div results still write back.
- sb_busy = |pending.
- Asynchronous reset mid-operation clears all state immediately. It does not wait for a clock edge.
- Latency: fwd_data/fwd_sel/stall_id are zero-cycle combinational. State updates take effect on the following cycle.

Optional Feature:
FWD_HAZARD_STATS_EN:
- Defined: adds output ports stat_stall_cycles[31:0] and stat_fwd_count[31:0], both saturating counters reset to 0 by rst_n.
  - stat_stall_cycles increments each cycle stall_id=1.
  - stat_fwd_count increments by the number of operands with fwd_sel!=0 in cycles with ex_stall=0.
- Undefined: these ports and counters do not exist, and functional behaviour is identical.

Test Plan:
- MEM/WB priority: ex_rs0=5, mem_rd=5 with result 0x11, wb_rd=5 with result 0x22, both regwrite -> fwd_data0=0x11, fwd_sel0=1. Drop mem_regwrite -> 0x22, sel=2.
- x0 guard: ex_rs1=0, mem_rd=0, mem_regwrite=1, mem_result=0xDEAD -> fwd_data1=ex_rs_data1, fwd_sel1=0.
- Load-use: ex_is_load, ex_rd=7, id_rs0=7, id_valid -> stall_id=1 for exactly 1 cycle after EX is bubbled.
- Scoreboard: lc_issue with lc_rd=9, then id_rs1=9 -> stall_id=1 and sb_busy=1 until lc_wb with wb_rd=9 -> stall_id=0 next cycle, sb_busy=0.
- Hold: ex_stall=1, wb_rd=3, wb_result=0xABCD, ex_rs0=3, then WB moves on -> fwd_sel0=3, fwd_data0=0xABCD. Assert flush -> sel returns to 0.
- Reset mid-op: set pending[4] and hold_vld, pulse rst_n=0 asynchronously -> sb_busy=0 and fwd_sel=0 immediately.
